// File: rtl/l2_cache_if.sv
// L1-side request bus and memory-side line bus of the L2 cache, bundled as one interface.
// The cache takes the slave view; the L1/memory environment takes the master view.
interface l2_cache_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [127:0] proc_wdata;
    logic [127:0] proc_rdata;
    logic         proc_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 line cache between the L1 and main memory.
// state     | meaning
// IDLE      | serve hits, launch victim write-back or refill, install clean write misses
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | requested line being fetched from memory
module l2_cache #(
    parameter int NUM_OF_SET = 16,
    parameter int SET_OFFSET = 4
) (
    input  logic       clk,
    input  logic       proc_reset,
    l2_cache_if.slave  bus
);
    localparam int TAG_W = 28 - SET_OFFSET;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                r_state;
    logic [NUM_OF_SET-1:0] r_valid;
    logic [NUM_OF_SET-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag  [NUM_OF_SET];
    logic [127:0]          r_data [NUM_OF_SET];

    logic [SET_OFFSET-1:0] w_set;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_hit;
    logic                  w_victim_dirty;

    assign w_set          = bus.proc_addr[SET_OFFSET+1:2];
    assign w_tag          = bus.proc_addr[29:SET_OFFSET+2];
    assign w_rd           = bus.proc_read & ~bus.proc_write;
    assign w_wr           = bus.proc_write & ~bus.proc_read;
    assign w_hit          = r_valid[w_set] && (r_tag[w_set] == w_tag);
    assign w_victim_dirty = r_valid[w_set] && r_dirty[w_set];

    // Outputs are combinational so hits and memory requests are visible in the request cycle.
    always_comb begin
        bus.proc_ready = 1'b0;
        bus.proc_rdata = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (r_state)
            IDLE: begin
                if (w_rd || w_wr) begin
                    if (w_hit) begin
                        bus.proc_ready = 1'b1;
                        if (w_rd) bus.proc_rdata = r_data[w_set];
                    end else if (w_victim_dirty) begin
                        bus.mem_write = 1'b1;
                        bus.mem_addr  = {r_tag[w_set], w_set};
                        bus.mem_wdata = r_data[w_set];
                    end else if (w_rd) begin
                        bus.mem_read = 1'b1;
                        bus.mem_addr = bus.proc_addr[29:2];
                    end else begin
                        bus.proc_ready = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {r_tag[w_set], w_set};
                bus.mem_wdata = r_data[w_set];
            end
            ALLOCATE: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = bus.proc_addr[29:2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < NUM_OF_SET; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rd || w_wr) begin
                        if (w_hit) begin
                            if (w_wr) begin
                                r_data[w_set]  <= bus.proc_wdata;
                                r_dirty[w_set] <= 1'b1;
                            end
                        end else if (w_victim_dirty) begin
                            if (bus.mem_ready) begin
                                r_dirty[w_set] <= 1'b0;
                                if (w_rd) r_state <= ALLOCATE;
                            end else begin
                                r_state <= WRITEBACK;
                            end
                        end else if (w_rd) begin
                            if (bus.mem_ready) begin
                                r_data[w_set]  <= bus.mem_rdata;
                                r_tag[w_set]   <= w_tag;
                                r_valid[w_set] <= 1'b1;
                                r_dirty[w_set] <= 1'b0;
                            end else begin
                                r_state <= ALLOCATE;
                            end
                        end else begin
                            // full-line write: no fetch needed
                            r_data[w_set]  <= bus.proc_wdata;
                            r_tag[w_set]   <= w_tag;
                            r_valid[w_set] <= 1'b1;
                            r_dirty[w_set] <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        r_dirty[w_set] <= 1'b0;
                        r_state        <= w_rd ? ALLOCATE : IDLE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_data[w_set]  <= bus.mem_rdata;
                        r_tag[w_set]   <= w_tag;
                        r_valid[w_set] <= 1'b1;
                        r_dirty[w_set] <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
